// File: rtl/rx_dma_sched.sv
// Round-robin frame scheduler for the two-PHY receive DMA path.
// Grants the shared receive engine one frame at a time and owns both ring-buffer write pointers.
module rx_dma_sched #(
    parameter int SLOT_WORDS  = 32,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [1:0]   dma_en,
    input  logic [21:2]  dma_length,
    input  logic [31:2]  dma1_addr_start,
    input  logic [31:2]  dma2_addr_start,
    input  logic [7:0]   phy1_rx_count,
    input  logic [7:0]   phy2_rx_count,
    output logic         grant_valid,
    output logic         grant_sel,
    output logic [31:2]  grant_addr,
    input  logic         done,
    output logic         abort,
    output logic [31:2]  dma1_addr_cur,
    output logic [31:2]  dma2_addr_cur,
    output logic [7:0]   dma1_rx_count,
    output logic [7:0]   dma2_rx_count,
    output logic [7:0]   err_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic        last_sel_q, last_sel_d;
    logic        grant_valid_q, grant_valid_d;
    logic        grant_sel_q, grant_sel_d;
    logic [29:0] grant_addr_q, grant_addr_d;
    logic        abort_q, abort_d;
    logic [29:0] addr1_q, addr1_d;
    logic [29:0] addr2_q, addr2_d;
    logic [7:0]  cnt1_q, cnt1_d;
    logic [7:0]  cnt2_q, cnt2_d;
    logic [7:0]  err_q, err_d;

    logic        pend1, pend2, sel;
    logic [29:0] sel_cur;
    logic [29:0] upd_cur, upd_start, upd_next;
    logic [19:0] upd_off;
    logic [20:0] upd_nxt, upd_end;

    assign pend1   = dma_en[0] & (phy1_rx_count != cnt1_q);
    assign pend2   = dma_en[1] & (phy2_rx_count != cnt2_q);
    assign sel     = (pend1 & pend2) ? ~last_sel_q : pend2;
    assign sel_cur = sel ? addr2_q : addr1_q;

    // Next-slot arithmetic for the channel being retired; the slot after next must fit or we wrap.
    assign upd_cur   = grant_sel_q ? addr2_q : addr1_q;
    assign upd_start = grant_sel_q ? dma2_addr_start : dma1_addr_start;
    assign upd_off   = upd_cur[19:0] - upd_start[19:0];
    assign upd_nxt   = {1'b0, upd_off} + 21'(SLOT_WORDS);
    assign upd_end   = upd_nxt + 21'(SLOT_WORDS);
    assign upd_next  = (upd_end > {1'b0, dma_length}) ? upd_start
                                                       : upd_start + {9'b0, upd_nxt};

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        last_sel_d    = last_sel_q;
        grant_valid_d = grant_valid_q;
        grant_sel_d   = grant_sel_q;
        grant_addr_d  = grant_addr_q;
        abort_d       = 1'b0;
        addr1_d       = addr1_q;
        addr2_d       = addr2_q;
        cnt1_d        = cnt1_q;
        cnt2_d        = cnt2_q;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!dma_en[0]) begin
                    addr1_d = dma1_addr_start;
                    cnt1_d  = phy1_rx_count;
                end else if (addr1_q == '0) begin
                    addr1_d = dma1_addr_start;
                end
                if (!dma_en[1]) begin
                    addr2_d = dma2_addr_start;
                    cnt2_d  = phy2_rx_count;
                end else if (addr2_q == '0) begin
                    addr2_d = dma2_addr_start;
                end
                // A channel whose pointer is still unloaded waits one cycle for its base.
                if ((pend1 | pend2) && (sel_cur != '0)) begin
                    grant_sel_d   = sel;
                    grant_addr_d  = sel_cur;
                    grant_valid_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                timer_d = timer_q + 12'd1;
                if (done) begin
                    grant_valid_d = 1'b0;
                    state_d       = ST_UPDATE;
                end else if (timer_q == 12'(TIMEOUT_CYC)) begin
                    grant_valid_d = 1'b0;
                    abort_d       = 1'b1;
                    err_d         = (err_q == 8'hff) ? 8'hff : err_q + 8'd1;
                    state_d       = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (grant_sel_q) begin
                    cnt2_d  = cnt2_q + 8'd1;
                    addr2_d = upd_next;
                end else begin
                    cnt1_d  = cnt1_q + 8'd1;
                    addr1_d = upd_next;
                end
                last_sel_d = grant_sel_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            last_sel_q    <= 1'b1;
            grant_valid_q <= 1'b0;
            grant_sel_q   <= 1'b0;
            grant_addr_q  <= '0;
            abort_q       <= 1'b0;
            addr1_q       <= '0;
            addr2_q       <= '0;
            cnt1_q        <= '0;
            cnt2_q        <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_sel_q    <= last_sel_d;
            grant_valid_q <= grant_valid_d;
            grant_sel_q   <= grant_sel_d;
            grant_addr_q  <= grant_addr_d;
            abort_q       <= abort_d;
            addr1_q       <= addr1_d;
            addr2_q       <= addr2_d;
            cnt1_q        <= cnt1_d;
            cnt2_q        <= cnt2_d;
            err_q         <= err_d;
        end
    end

    assign grant_valid   = grant_valid_q;
    assign grant_sel     = grant_sel_q;
    assign grant_addr    = grant_addr_q;
    assign abort         = abort_q;
    assign dma1_addr_cur = addr1_q;
    assign dma2_addr_cur = addr2_q;
    assign dma1_rx_count = cnt1_q;
    assign dma2_rx_count = cnt2_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_rx_dma_sched.sv
// Self-checking bench for rx_dma_sched: table-driven ring-pointer vectors with a grant
// scoreboard, plus hand-written sequences for alternation, timeout, reset and disable cases.
module tb_rx_dma_sched;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [1:0]  dma_en;
    logic [19:0] dma_length;
    logic [29:0] dma1_addr_start;
    logic [29:0] dma2_addr_start;
    logic [7:0]  phy1_rx_count;
    logic [7:0]  phy2_rx_count;
    logic        grant_valid;
    logic        grant_sel;
    logic [29:0] grant_addr;
    logic        done;
    logic        abort;
    logic [29:0] dma1_addr_cur;
    logic [29:0] dma2_addr_cur;
    logic [7:0]  dma1_rx_count;
    logic [7:0]  dma2_rx_count;
    logic [7:0]  err_count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        sel;
        logic [29:0] addr;
    } grant_t;

    typedef struct {
        logic [19:0] len;
        int          frames;
        logic [29:0] expCur;
        logic [7:0]  expCnt;
    } vec_t;

    grant_t sb[$];
    vec_t   vecs[5];

    rx_dma_sched dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .dma_en          (dma_en),
        .dma_length      (dma_length),
        .dma1_addr_start (dma1_addr_start),
        .dma2_addr_start (dma2_addr_start),
        .phy1_rx_count   (phy1_rx_count),
        .phy2_rx_count   (phy2_rx_count),
        .grant_valid     (grant_valid),
        .grant_sel       (grant_sel),
        .grant_addr      (grant_addr),
        .done            (done),
        .abort           (abort),
        .dma1_addr_cur   (dma1_addr_cur),
        .dma2_addr_cur   (dma2_addr_cur),
        .dma1_rx_count   (dma1_rx_count),
        .dma2_rx_count   (dma2_rx_count),
        .err_count       (err_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [19:0] len,
                                 input logic [29:0] s1, input logic [29:0] s2,
                                 input logic [7:0] p1, input logic [7:0] p2);
        dma_en          = en;
        dma_length      = len;
        dma1_addr_start = s1;
        dma2_addr_start = s2;
        phy1_rx_count   = p1;
        phy2_rx_count   = p2;
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        done      = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic waitGrant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!ok) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL grant_wait: got no grant_valid within 50 cycles, expected 1");
        end
    endtask

    // Waits for a grant, compares it with the scoreboard head and completes it with done.
    task automatic serveFrame();
        bit     ok;
        grant_t e;
        waitGrant(ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL sb_empty: got unexpected grant sel=%0d addr=0x%0h", grant_sel, grant_addr);
        end else begin
            e = sb.pop_front();
            checkOutput("grant_sel", {31'b0, grant_sel}, {31'b0, e.sel});
            checkOutput("grant_addr", {2'b0, grant_addr}, {2'b0, e.addr});
        end
        done = 1'b1;
        @(negedge sys_clk);
        done = 1'b0;
        checkOutput("grant_drop", {31'b0, grant_valid}, 32'd0);
        @(negedge sys_clk);
    endtask

    initial begin
        int     n;
        int     slots;
        bit     ok;
        grant_t g;

        vecs[0] = '{len: 20'd1024, frames: 1, expCur: 30'h1020, expCnt: 8'd1};
        vecs[1] = '{len: 20'd64,   frames: 4, expCur: 30'h1000, expCnt: 8'd4};
        vecs[2] = '{len: 20'd40,   frames: 3, expCur: 30'h1000, expCnt: 8'd3};
        vecs[3] = '{len: 20'd96,   frames: 2, expCur: 30'h1040, expCnt: 8'd2};
        vecs[4] = '{len: 20'd100,  frames: 4, expCur: 30'h1020, expCnt: 8'd4};

        done = 1'b0;
        sys_rst_n = 1'b0;
        applyStimulus(2'b01, 20'd1024, 30'h1000, 30'h2000, 8'd0, 8'd0);
        repeat (2) @(negedge sys_clk);
        checkOutput("rst_grant_valid", {31'b0, grant_valid}, 32'd0);
        checkOutput("rst_grant_sel", {31'b0, grant_sel}, 32'd0);
        checkOutput("rst_grant_addr", {2'b0, grant_addr}, 32'd0);
        checkOutput("rst_abort", {31'b0, abort}, 32'd0);
        checkOutput("rst_addr1", {2'b0, dma1_addr_cur}, 32'd0);
        checkOutput("rst_addr2", {2'b0, dma2_addr_cur}, 32'd0);
        checkOutput("rst_cnt1", {24'b0, dma1_rx_count}, 32'd0);
        checkOutput("rst_err", {24'b0, err_count}, 32'd0);
        sys_rst_n = 1'b1;

        // Channel-1 ring walks: expected slot sequence derived from the number of whole slots.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(2'b01, vecs[v].len, 30'h1000, 30'h2000, 8'(vecs[v].frames), 8'd0);
            doReset();
            slots = int'(vecs[v].len) / 32;
            if (slots < 1) slots = 1;
            for (int k = 0; k < vecs[v].frames; k++) begin
                g.sel  = 1'b0;
                g.addr = 30'h1000 + 30'(32 * (k % slots));
                sb.push_back(g);
            end
            for (int k = 0; k < vecs[v].frames; k++) serveFrame();
            checkOutput($sformatf("vec%0d_addr1", v), {2'b0, dma1_addr_cur}, {2'b0, vecs[v].expCur});
            checkOutput($sformatf("vec%0d_cnt1", v), {24'b0, dma1_rx_count}, {24'b0, vecs[v].expCnt});
            checkOutput($sformatf("vec%0d_sb_left", v), 32'(sb.size()), 32'd0);
            sb.delete();
        end

        // Both channels pending from reset: phy1 first, then strict alternation.
        applyStimulus(2'b11, 20'd1024, 30'h1000, 30'h2000, 8'd2, 8'd2);
        doReset();
        sb.push_back('{sel: 1'b0, addr: 30'h1000});
        sb.push_back('{sel: 1'b1, addr: 30'h2000});
        sb.push_back('{sel: 1'b0, addr: 30'h1020});
        sb.push_back('{sel: 1'b1, addr: 30'h2020});
        for (int k = 0; k < 4; k++) serveFrame();
        checkOutput("alt_cnt1", {24'b0, dma1_rx_count}, 32'd2);
        checkOutput("alt_cnt2", {24'b0, dma2_rx_count}, 32'd2);
        checkOutput("alt_addr2", {2'b0, dma2_addr_cur}, 32'h2040);
        sb.delete();

        // Timeout: abort after 4096 BUSY cycles with no done.
        applyStimulus(2'b01, 20'd1024, 30'h1000, 30'h2000, 8'd1, 8'd0);
        doReset();
        waitGrant(ok);
        checkOutput("to_grant_addr", {2'b0, grant_addr}, 32'h1000);
        n = 0;
        while (!abort && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("to_abort", {31'b0, abort}, 32'd1);
        checkOutput("to_cycles", 32'(n), 32'd4096);
        checkOutput("to_err", {24'b0, err_count}, 32'd1);
        checkOutput("to_grant_drop", {31'b0, grant_valid}, 32'd0);
        @(negedge sys_clk);
        checkOutput("to_abort_pulse", {31'b0, abort}, 32'd0);
        checkOutput("to_cnt1", {24'b0, dma1_rx_count}, 32'd1);
        checkOutput("to_addr1", {2'b0, dma1_addr_cur}, 32'h1020);

        // done coinciding with the timeout cycle wins; no abort.
        phy1_rx_count = 8'd2;
        waitGrant(ok);
        checkOutput("tie_grant_addr", {2'b0, grant_addr}, 32'h1020);
        repeat (4095) @(negedge sys_clk);
        done = 1'b1;
        @(negedge sys_clk);
        done = 1'b0;
        checkOutput("tie_no_abort", {31'b0, abort}, 32'd0);
        checkOutput("tie_grant_drop", {31'b0, grant_valid}, 32'd0);
        checkOutput("tie_err", {24'b0, err_count}, 32'd1);
        @(negedge sys_clk);
        checkOutput("tie_cnt1", {24'b0, dma1_rx_count}, 32'd2);
        checkOutput("tie_addr1", {2'b0, dma1_addr_cur}, 32'h1040);

        // Reset while a frame is in BUSY clears everything on the next edge.
        phy1_rx_count = 8'd3;
        waitGrant(ok);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checkOutput("mid_rst_grant", {31'b0, grant_valid}, 32'd0);
        checkOutput("mid_rst_cnt1", {24'b0, dma1_rx_count}, 32'd0);
        checkOutput("mid_rst_addr1", {2'b0, dma1_addr_cur}, 32'd0);
        checkOutput("mid_rst_err", {24'b0, err_count}, 32'd0);
        sys_rst_n = 1'b1;

        // Disabled channel 2 with backlog: no grant, backlog absorbed, pointer at base.
        applyStimulus(2'b01, 20'd1024, 30'h1000, 30'h2000, 8'd0, 8'd5);
        doReset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (grant_valid) n++;
        end
        checkOutput("dis_no_grant", 32'(n), 32'd0);
        checkOutput("dis_cnt2", {24'b0, dma2_rx_count}, 32'd5);
        checkOutput("dis_addr2", {2'b0, dma2_addr_cur}, 32'h2000);
        dma_en = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            if (grant_valid) n++;
        end
        checkOutput("en_no_stale_grant", 32'(n), 32'd0);

        // Disable during BUSY: frame completes, then the IDLE reload rewinds the pointer.
        applyStimulus(2'b01, 20'd1024, 30'h1000, 30'h2000, 8'd1, 8'd0);
        doReset();
        waitGrant(ok);
        dma_en = 2'b00;
        @(negedge sys_clk);
        checkOutput("dis_busy_no_abort", {31'b0, grant_valid}, 32'd1);
        done = 1'b1;
        @(negedge sys_clk);
        done = 1'b0;
        @(negedge sys_clk);
        checkOutput("dis_busy_cnt1", {24'b0, dma1_rx_count}, 32'd1);
        checkOutput("dis_busy_addr1", {2'b0, dma1_addr_cur}, 32'h1020);
        @(negedge sys_clk);
        checkOutput("dis_busy_reload", {2'b0, dma1_addr_cur}, 32'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
